jb_xssi_chan_sched: RTL and testbench

- Round-robin scheduler that time-shares one RSSI power accumulator across NUM_CHAN antenna channels.
- Per channel, in order: clear the accumulator, enable it for a window of cfg_num_tics 15.36 MHz tics, then hand the result off to the result store over a valid/ready handshake.
- Sits between the common-control config registers and the shared accumulator / result-RAM writer in the xssi path.

---
 rtl/jb_xssi_chan_sched.sv | 182 ++++++++++++++++++
 tb/tb_jb_xssi_chan_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jb_xssi_chan_sched.sv
// Round-robin scheduler time-sharing one RSSI accumulator across NUM_CHAN channels.
// Optional settle phase after each channel switch: define JB_XSSI_SCHED_SETTLE_EN.
module jb_xssi_chan_sched #(
  parameter int MAX_RSSI_TICS_BW = 21,
  parameter int NUM_CHAN         = 4,
  parameter int CHAN_BW          = 2
) (
  input  logic                        clk_15p36,
  input  logic                        resetn_15p36,
  input  logic [MAX_RSSI_TICS_BW-1:0] cfg_num_tics,
  input  logic [NUM_CHAN-1:0]         cfg_chan_en,
`ifdef JB_XSSI_SCHED_SETTLE_EN
  input  logic [7:0]                  cfg_settle_tics,
`endif
  output logic                        acc_clr,
  output logic                        acc_en,
  output logic [CHAN_BW-1:0]          chan_sel,
  output logic                        dump_valid,
  input  logic                        dump_ready,
  output logic [CHAN_BW-1:0]          dump_chan,
  output logic                        sweep_done,
  output logic [15:0]                 sweep_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
`ifdef JB_XSSI_SCHED_SETTLE_EN
    ST_SETTLE,
`endif
    ST_DUMP
  } state_t;

  localparam logic [MAX_RSSI_TICS_BW-1:0] TIC_ONE = 1;

  state_t                      state_q, state_d;
  logic [CHAN_BW-1:0]          chan_q, chan_d;
  logic [CHAN_BW-1:0]          ptr_q, ptr_d;
  logic [MAX_RSSI_TICS_BW-1:0] tic_q, tic_d;
  logic [MAX_RSSI_TICS_BW-1:0] shadow_q, shadow_d;
  logic                        done_q, done_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [CHAN_BW:0]            pick_idle, pick_next;
  logic                        cfg_ok;
`ifdef JB_XSSI_SCHED_SETTLE_EN
  logic [7:0]                  settle_sh_q, settle_sh_d;
  logic [7:0]                  settle_q, settle_d;
`endif

  // Lowest enabled channel at index >= start, wrapping to the lowest overall.
  // Returns {found, index}.
  function automatic logic [CHAN_BW:0] pick(input logic [NUM_CHAN-1:0] mask,
                                            input int start);
    logic               found_hi, found_any;
    logic [CHAN_BW-1:0] hi, lo;
    found_hi  = 1'b0;
    found_any = 1'b0;
    hi        = '0;
    lo        = '0;
    for (int j = NUM_CHAN - 1; j >= 0; j--) begin
      if (mask[j]) begin
        found_any = 1'b1;
        lo        = j[CHAN_BW-1:0];
        if (j >= start) begin
          found_hi = 1'b1;
          hi       = j[CHAN_BW-1:0];
        end
      end
    end
    return found_hi ? {1'b1, hi} : {found_any, lo};
  endfunction

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    ptr_d       = ptr_q;
    tic_d       = tic_q;
    shadow_d    = shadow_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
`ifdef JB_XSSI_SCHED_SETTLE_EN
    settle_sh_d = settle_sh_q;
    settle_d    = settle_q;
`endif
    cfg_ok    = (cfg_num_tics != '0) && (cfg_chan_en != '0);
    pick_idle = pick(cfg_chan_en, int'(ptr_q));
    pick_next = pick(cfg_chan_en, int'(chan_q) + 1);

    case (state_q)
      ST_IDLE: begin
        if (cfg_ok && pick_idle[CHAN_BW]) begin
          chan_d      = pick_idle[CHAN_BW-1:0];
          shadow_d    = cfg_num_tics;
`ifdef JB_XSSI_SCHED_SETTLE_EN
          settle_sh_d = cfg_settle_tics;
`endif
          state_d     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        tic_d   = '0;
        state_d = ST_ACCUM;
`ifdef JB_XSSI_SCHED_SETTLE_EN
        settle_d = '0;
        if (settle_sh_q != '0) state_d = ST_SETTLE;
`endif
      end
`ifdef JB_XSSI_SCHED_SETTLE_EN
      ST_SETTLE: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == settle_sh_q - 8'd1) state_d = ST_ACCUM;
      end
`endif
      ST_ACCUM: begin
        tic_d = tic_q + TIC_ONE;
        if (tic_q == shadow_q - TIC_ONE) state_d = ST_DUMP;
      end
      ST_DUMP: begin
        if (dump_ready) begin
          // Next selection is strictly after the current channel; landing at or
          // below it means the sweep wrapped.
          if (pick_next[CHAN_BW]) begin
            ptr_d = pick_next[CHAN_BW-1:0];
            if (pick_next[CHAN_BW-1:0] <= chan_q) begin
              done_d = 1'b1;
              cnt_d  = cnt_q + 16'd1;
            end
          end
          if (cfg_ok) begin
            chan_d      = pick_next[CHAN_BW-1:0];
            shadow_d    = cfg_num_tics;
`ifdef JB_XSSI_SCHED_SETTLE_EN
            settle_sh_d = cfg_settle_tics;
`endif
            state_d     = ST_CLEAR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_15p36 or negedge resetn_15p36) begin
    if (!resetn_15p36) begin
      state_q     <= ST_IDLE;
      chan_q      <= '0;
      ptr_q       <= '0;
      tic_q       <= '0;
      shadow_q    <= '0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
`ifdef JB_XSSI_SCHED_SETTLE_EN
      settle_sh_q <= '0;
      settle_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      ptr_q       <= ptr_d;
      tic_q       <= tic_d;
      shadow_q    <= shadow_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
`ifdef JB_XSSI_SCHED_SETTLE_EN
      settle_sh_q <= settle_sh_d;
      settle_q    <= settle_d;
`endif
    end
  end

  assign acc_clr    = (state_q == ST_CLEAR);
  assign acc_en     = (state_q == ST_ACCUM);
  assign dump_valid = (state_q == ST_DUMP);
  assign chan_sel   = chan_q;
  assign dump_chan  = chan_q;
  assign sweep_done = done_q;
  assign sweep_cnt  = cnt_q;

endmodule

// File: tb/tb_jb_xssi_chan_sched.sv
// Directed bench for jb_xssi_chan_sched: window timing, ordering, backpressure,
// reconfiguration, sweep counting and asynchronous reset.
module tb_jb_xssi_chan_sched;

  logic        clk_15p36 = 1'b0;
  logic        resetn_15p36 = 1'b1;
  logic [20:0] cfg_num_tics = '0;
  logic [3:0]  cfg_chan_en = '0;
  logic [7:0]  cfg_settle_tics = '0;
  logic        dump_ready = 1'b1;
  logic        acc_clr, acc_en, dump_valid, sweep_done;
  logic [1:0]  chan_sel, dump_chan;
  logic [15:0] sweep_cnt;

  int total = 0;
  int bad   = 0;

  jb_xssi_chan_sched dut (
    .clk_15p36    (clk_15p36),
    .resetn_15p36 (resetn_15p36),
    .cfg_num_tics (cfg_num_tics),
    .cfg_chan_en  (cfg_chan_en),
`ifdef JB_XSSI_SCHED_SETTLE_EN
    .cfg_settle_tics (cfg_settle_tics),
`endif
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .chan_sel     (chan_sel),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_chan    (dump_chan),
    .sweep_done   (sweep_done),
    .sweep_cnt    (sweep_cnt)
  );

  always #5 clk_15p36 = ~clk_15p36;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_15p36);
    #1;
  endtask

  // One channel window: starts on (or waits for) the acc_clr cycle, ends on
  // the cycle after the dump handshake.
  task automatic win(input string tag, input int exp_chan, input int exp_en,
                     input int exp_done, input int stall);
    int n;
    int steps;
    n = 0;
    while (!acc_clr && n < 64) begin
      step();
      n++;
    end
    chk_eq({tag, "_clr"}, 32'(acc_clr), 1);
    chk_eq({tag, "_chan"}, 32'(chan_sel), exp_chan);
    dump_ready = (stall == 0);
    steps = 1;
    n = 0;
    step();
    while (acc_en && n < 64) begin
      n++;
      steps++;
      step();
    end
    chk_eq({tag, "_en_cycles"}, n, exp_en);
    chk_eq({tag, "_dvalid"}, 32'(dump_valid), 1);
    chk_eq({tag, "_dchan"}, 32'(dump_chan), exp_chan);
    for (int s = 0; s < stall; s++) begin
      step();
      steps++;
      chk_eq({tag, "_stall"}, {dump_valid, acc_en, acc_clr, dump_chan},
             {1'b1, 1'b0, 1'b0, 2'(exp_chan)});
    end
    dump_ready = 1'b1;
    step();
    steps++;
    chk_eq({tag, "_period"}, steps, 2 + exp_en + stall);
    chk_eq({tag, "_dv_off"}, 32'(dump_valid), 0);
    chk_eq({tag, "_sweep_done"}, 32'(sweep_done), exp_done);
  endtask

  initial begin
    #2 resetn_15p36 = 1'b0;
    #1;
    chk_eq("rst_acc_clr", 32'(acc_clr), 0);
    chk_eq("rst_acc_en", 32'(acc_en), 0);
    chk_eq("rst_dvalid", 32'(dump_valid), 0);
    chk_eq("rst_chan", {chan_sel, dump_chan}, 0);
    chk_eq("rst_sweep", {sweep_done, sweep_cnt}, 0);
    step();
    cfg_num_tics = 21'd8;
    cfg_chan_en  = 4'b1111;
    resetn_15p36 = 1'b1;

    // Basic sweep
    win("b0", 0, 8, 0, 0);
    win("b1", 1, 8, 0, 0);
    win("b2", 2, 8, 0, 0);
    win("b3", 3, 8, 1, 0);
    chk_eq("b_cnt", 32'(sweep_cnt), 1);
    win("b4", 0, 8, 0, 0);

    // Sparse mask, changed during the ch1 window (still runs 8 tics)
    cfg_chan_en  = 4'b1010;
    cfg_num_tics = 21'd3;
    win("s1", 1, 8, 0, 0);
    win("s3", 3, 3, 1, 0);
    win("s1b", 1, 3, 0, 0);
    win("s3b", 3, 3, 1, 0);
    chk_eq("s_cnt", 32'(sweep_cnt), 3);

    // Backpressure
    win("bp1", 1, 3, 0, 5);
    win("bp3", 3, 3, 1, 0);

    // Reconfigure 8 -> 4 mid-window
    cfg_num_tics = 21'd8;
    win("r1", 1, 3, 0, 0);
    cfg_num_tics = 21'd4;
    win("r3", 3, 8, 1, 0);
    win("r1b", 1, 4, 0, 0);

    // Disable mid-window: window completes, then idle
    cfg_num_tics = 21'd0;
    win("d3", 3, 4, 1, 0);
    step();
    step();
    chk_eq("idle_quiet", {acc_clr, acc_en, dump_valid}, 0);
    chk_eq("idle_chan_hold", 32'(chan_sel), 3);
    chk_eq("d_cnt", 32'(sweep_cnt), 6);

    // One-tic windows, resuming after the last served channel
    cfg_num_tics = 21'd1;
    cfg_chan_en  = 4'b1111;
    step();
    chk_eq("idle_lat", 32'(acc_clr), 1);
    win("t1", 1, 1, 0, 0);
    win("t2", 2, 1, 0, 0);
    win("t3", 3, 1, 1, 0);
    win("t0", 0, 1, 0, 0);

    // Single channel
    cfg_chan_en  = 4'b0100;
    cfg_num_tics = 21'd2;
    win("u1", 1, 1, 0, 0);
    win("u2", 2, 2, 1, 0);
    win("u2b", 2, 2, 1, 0);
    chk_eq("u_cnt", 32'(sweep_cnt), 9);

    // Sweep counter wrap
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    win("w0", 2, 2, 1, 0);
    chk_eq("wrap_ffff", 32'(sweep_cnt), 32'hFFFF);
    win("w1", 2, 2, 1, 0);
    chk_eq("wrap_zero", 32'(sweep_cnt), 0);

    // Asynchronous reset in the middle of a window
    step();
    chk_eq("mid_acc_en", 32'(acc_en), 1);
    #2 resetn_15p36 = 1'b0;
    #1;
    chk_eq("amid_quiet", {acc_clr, acc_en, dump_valid, sweep_done}, 0);
    chk_eq("amid_chan", {chan_sel, dump_chan}, 0);
    cfg_chan_en  = 4'b1111;
    cfg_num_tics = 21'd2;
    #1 resetn_15p36 = 1'b1;
    step();
    chk_eq("arst_restart_clr", {acc_clr, dump_valid}, 2'b10);
    win("a0", 0, 2, 0, 0);
    win("a1", 1, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
